gray_sequence_monitor: RTL and testbench

- Downstream consumer of a Gray-code counter output.
- Samples a Gray word, decodes it to binary and checks that each new sample is a legal neighbour of the previous one (+1, -1 or hold, modulo 2^WIDTH).
- Reports step direction, flags illegal jumps and keeps a saturating error count.
- Tracks lock status through a small acquire/lock state machine; used as a link-integrity checker on Gray-coded counter and pointer buses.

---
 rtl/gray_sequence_monitor_if.sv | 26 ++
 rtl/gray_sequence_monitor.sv | 151 +++++++++++++++
 tb/tb_gray_sequence_monitor.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/gray_sequence_monitor_if.sv
// Sample/status bundle between a Gray-code source and the sequence monitor.
interface gray_sequence_monitor_if #(
  parameter int WIDTH         = 4,
  parameter int ERR_CNT_WIDTH = 8
);
  logic                     sample_valid;
  logic [WIDTH-1:0]         gray_in;
  logic                     clear_err;
  logic [WIDTH-1:0]         binary_out;
  logic                     step_up;
  logic                     step_down;
  logic                     hold;
  logic                     bit_error;
  logic                     locked;
  logic [ERR_CNT_WIDTH-1:0] err_count;

  modport master (
    output sample_valid, gray_in, clear_err,
    input  binary_out, step_up, step_down, hold, bit_error, locked, err_count
  );

  modport slave (
    input  sample_valid, gray_in, clear_err,
    output binary_out, step_up, step_down, hold, bit_error, locked, err_count
  );
endinterface

// File: rtl/gray_sequence_monitor.sv
// Gray-code sequence monitor: decodes each sample, classifies it against the
// previous value (+1 / -1 / hold / illegal) and tracks link lock.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no reference value yet; next sample is captured silently
// ACQUIRE | reference held, counting consecutive legal steps
// LOCKED  | LOCK_COUNT consecutive steps seen; any illegal jump drops lock
module gray_sequence_monitor #(
  parameter int WIDTH         = 4,
  parameter int LOCK_COUNT    = 4,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  gray_sequence_monitor_if.slave bus
);

  localparam int RUN_W = $clog2(LOCK_COUNT + 1);
  localparam logic [RUN_W-1:0]         LOCK_RUN = RUN_W'(LOCK_COUNT);
  localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX  = '1;

  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

  state_t                   state_q, state_d;
  logic [RUN_W-1:0]         run_q, run_d, run_inc;
  logic [WIDTH-1:0]         prev_q, prev_d, prev_inc, prev_dec;
  logic [WIDTH-1:0]         dec;
  logic                     is_up, is_down, is_hold, is_step;

  logic [WIDTH-1:0]         bin_q, bin_d;
  logic                     up_q, up_d;
  logic                     down_q, down_d;
  logic                     hold_q, hold_d;
  logic                     err_q, err_d;
  logic                     locked_q, locked_d;
  logic [ERR_CNT_WIDTH-1:0] cnt_q, cnt_d;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    dec = bus.gray_in;
    for (int i = WIDTH - 2; i >= 0; i--) begin
      dec[i] = dec[i+1] ^ bus.gray_in[i];
    end
  end

  assign prev_inc = prev_q + WIDTH'(1);
  assign prev_dec = prev_q - WIDTH'(1);
  assign is_up    = (dec == prev_inc);
  assign is_down  = (dec == prev_dec);
  assign is_hold  = (dec == prev_q);
  assign is_step  = is_up | is_down;
  assign run_inc  = run_q + RUN_W'(1);

  // State register plus all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      run_q    <= '0;
      prev_q   <= '0;
      bin_q    <= '0;
      up_q     <= 1'b0;
      down_q   <= 1'b0;
      hold_q   <= 1'b0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      prev_q   <= prev_d;
      bin_q    <= bin_d;
      up_q     <= up_d;
      down_q   <= down_d;
      hold_q   <= hold_d;
      err_q    <= err_d;
      locked_q <= locked_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state logic, including the run counter and reference value.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    prev_d  = prev_q;
    unique case (state_q)
      IDLE: begin
        if (bus.sample_valid) begin
          prev_d  = dec;
          run_d   = '0;
          state_d = ACQUIRE;
        end
      end
      ACQUIRE: begin
        if (bus.sample_valid) begin
          if (is_step) begin
            prev_d = dec;
            run_d  = run_inc;
            if (run_inc == LOCK_RUN) state_d = LOCKED;
          end else if (!is_hold) begin
            // Resync to the new value so one glitch costs only one error.
            prev_d = dec;
            run_d  = '0;
          end
        end
      end
      LOCKED: begin
        if (bus.sample_valid) begin
          if (is_step) begin
            prev_d = dec;
          end else if (!is_hold) begin
            prev_d  = dec;
            run_d   = '0;
            state_d = ACQUIRE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    logic classify;
    classify = bus.sample_valid && (state_q != IDLE);
    up_d     = classify && is_up;
    down_d   = classify && is_down;
    hold_d   = classify && is_hold;
    err_d    = classify && !(is_step || is_hold);
    bin_d    = bus.sample_valid ? dec : bin_q;
    locked_d = (state_d == LOCKED);
    // Clear has priority over a coincident error.
    if (bus.clear_err) begin
      cnt_d = '0;
    end else if (err_d && (cnt_q != ERR_MAX)) begin
      cnt_d = cnt_q + ERR_CNT_WIDTH'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  assign bus.binary_out = bin_q;
  assign bus.step_up    = up_q;
  assign bus.step_down  = down_q;
  assign bus.hold       = hold_q;
  assign bus.bit_error  = err_q;
  assign bus.locked     = locked_q;
  assign bus.err_count  = cnt_q;

endmodule

// File: tb/tb_gray_sequence_monitor.sv
// Directed bench for gray_sequence_monitor: a WIDTH=4 / LOCK_COUNT=4 instance
// for sequencing, lock and reset, and a 2-bit error counter instance for saturation.
module tb_gray_sequence_monitor;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  // Pulse encodings as {step_up, step_down, hold, bit_error}.
  localparam logic [3:0] NP = 4'b0000;
  localparam logic [3:0] UP = 4'b1000;
  localparam logic [3:0] DN = 4'b0100;
  localparam logic [3:0] HD = 4'b0010;
  localparam logic [3:0] ER = 4'b0001;

  gray_sequence_monitor_if #(.WIDTH(4), .ERR_CNT_WIDTH(8)) bus_a ();
  gray_sequence_monitor_if #(.WIDTH(4), .ERR_CNT_WIDTH(2)) bus_b ();

  gray_sequence_monitor #(.WIDTH(4), .LOCK_COUNT(4), .ERR_CNT_WIDTH(8)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a.slave)
  );

  gray_sequence_monitor #(.WIDTH(4), .LOCK_COUNT(4), .ERR_CNT_WIDTH(2)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [3:0] bin, input logic [3:0] pul,
                       input logic lck, input logic [7:0] cnt);
    chk({tag, ".bin"},    32'(bus_a.binary_out), 32'(bin));
    chk({tag, ".pulse"},  32'({bus_a.step_up, bus_a.step_down, bus_a.hold, bus_a.bit_error}), 32'(pul));
    chk({tag, ".locked"}, 32'(bus_a.locked), 32'(lck));
    chk({tag, ".err"},    32'(bus_a.err_count), 32'(cnt));
  endtask

  task automatic chk_b(input string tag, input logic [3:0] bin, input logic [3:0] pul,
                       input logic lck, input logic [1:0] cnt);
    chk({tag, ".bin"},    32'(bus_b.binary_out), 32'(bin));
    chk({tag, ".pulse"},  32'({bus_b.step_up, bus_b.step_down, bus_b.hold, bus_b.bit_error}), 32'(pul));
    chk({tag, ".locked"}, 32'(bus_b.locked), 32'(lck));
    chk({tag, ".err"},    32'(bus_b.err_count), 32'(cnt));
  endtask

  task automatic step_a(input logic v, input logic [3:0] g, input logic c);
    bus_a.sample_valid = v;
    bus_a.gray_in      = g;
    bus_a.clear_err    = c;
    bus_b.sample_valid = 1'b0;
    bus_b.clear_err    = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic step_b(input logic v, input logic [3:0] g, input logic c);
    bus_b.sample_valid = v;
    bus_b.gray_in      = g;
    bus_b.clear_err    = c;
    bus_a.sample_valid = 1'b0;
    bus_a.clear_err    = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    bus_a.sample_valid = 1'b0; bus_a.gray_in = 4'h0; bus_a.clear_err = 1'b0;
    bus_b.sample_valid = 1'b0; bus_b.gray_in = 4'h0; bus_b.clear_err = 1'b0;

    // Asynchronous reset, mid-cycle.
    #2 rst_n = 1'b0;
    #1 chk_a("rst", 4'd0, NP, 1'b0, 8'd0);
    chk_b("rst_b", 4'd0, NP, 1'b0, 2'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    step_a(1'b0, 4'b0000, 1'b0); chk_a("post_rst0", 4'd0, NP, 1'b0, 8'd0);
    step_a(1'b0, 4'b0000, 1'b0); chk_a("post_rst1", 4'd0, NP, 1'b0, 8'd0);

    // Up count 0..5, lock on sample 4.
    step_a(1'b1, 4'b0000, 1'b0); chk_a("up0", 4'd0, NP, 1'b0, 8'd0);
    step_a(1'b1, 4'b0001, 1'b0); chk_a("up1", 4'd1, UP, 1'b0, 8'd0);
    step_a(1'b1, 4'b0011, 1'b0); chk_a("up2", 4'd2, UP, 1'b0, 8'd0);
    step_a(1'b1, 4'b0010, 1'b0); chk_a("up3", 4'd3, UP, 1'b0, 8'd0);
    step_a(1'b1, 4'b0110, 1'b0); chk_a("up4", 4'd4, UP, 1'b1, 8'd0);
    step_a(1'b1, 4'b0111, 1'b0); chk_a("up5", 4'd5, UP, 1'b1, 8'd0);
    step_a(1'b0, 4'b0111, 1'b0); chk_a("novalid", 4'd5, NP, 1'b1, 8'd0);

    // Illegal jump 5 -> 14 while locked, then relock through both wraps.
    step_a(1'b1, 4'b1001, 1'b0); chk_a("jump14", 4'd14, ER, 1'b0, 8'd1);
    step_a(1'b1, 4'b1000, 1'b0); chk_a("to15", 4'd15, UP, 1'b0, 8'd1);
    step_a(1'b1, 4'b0000, 1'b0); chk_a("wrap_up", 4'd0, UP, 1'b0, 8'd1);
    step_a(1'b1, 4'b1000, 1'b0); chk_a("wrap_dn", 4'd15, DN, 1'b0, 8'd1);
    step_a(1'b1, 4'b1001, 1'b0); chk_a("relock14", 4'd14, DN, 1'b1, 8'd1);
    step_a(1'b1, 4'b1001, 1'b0); chk_a("hold_lk", 4'd14, HD, 1'b1, 8'd1);

    // Hold during acquire leaves the run count alone.
    step_a(1'b1, 4'b0101, 1'b0); chk_a("jump6", 4'd6, ER, 1'b0, 8'd2);
    step_a(1'b1, 4'b0101, 1'b0); chk_a("hold6", 4'd6, HD, 1'b0, 8'd2);
    step_a(1'b1, 4'b0100, 1'b0); chk_a("acq7", 4'd7, UP, 1'b0, 8'd2);
    step_a(1'b1, 4'b1100, 1'b0); chk_a("acq8", 4'd8, UP, 1'b0, 8'd2);
    step_a(1'b1, 4'b1101, 1'b0); chk_a("acq9", 4'd9, UP, 1'b0, 8'd2);
    step_a(1'b1, 4'b1101, 1'b0); chk_a("hold9", 4'd9, HD, 1'b0, 8'd2);
    step_a(1'b1, 4'b1111, 1'b0); chk_a("lock10", 4'd10, UP, 1'b1, 8'd2);
    step_a(1'b1, 4'b1111, 1'b0); chk_a("hold10", 4'd10, HD, 1'b1, 8'd2);
    step_a(1'b1, 4'b1101, 1'b0); chk_a("down9", 4'd9, DN, 1'b1, 8'd2);

    // Reset while locked at 9.
    #2 rst_n = 1'b0;
    #1 chk_a("rst_lock", 4'd0, NP, 1'b0, 8'd0);
    @(negedge clk) rst_n = 1'b1;
    step_a(1'b0, 4'b0000, 1'b0); chk_a("rst_idle", 4'd0, NP, 1'b0, 8'd0);
    step_a(1'b1, 4'b1010, 1'b0); chk_a("cap12", 4'd12, NP, 1'b0, 8'd0);
    step_a(1'b1, 4'b1011, 1'b0); chk_a("acq13", 4'd13, UP, 1'b0, 8'd0);

    // Clear coincident with an error, then a counted error, then a bare clear.
    step_a(1'b1, 4'b0010, 1'b1); chk_a("clr_err", 4'd3, ER, 1'b0, 8'd0);
    step_a(1'b1, 4'b0000, 1'b0); chk_a("err_after", 4'd0, ER, 1'b0, 8'd1);
    step_a(1'b0, 4'b0000, 1'b1); chk_a("clr_only", 4'd0, NP, 1'b0, 8'd0);

    // Saturation on the 2-bit counter.
    step_b(1'b1, 4'b0000, 1'b0); chk_b("sat_cap", 4'd0, NP, 1'b0, 2'd0);
    step_b(1'b1, 4'b0011, 1'b0); chk_b("sat1", 4'd2, ER, 1'b0, 2'd1);
    step_b(1'b1, 4'b0000, 1'b0); chk_b("sat2", 4'd0, ER, 1'b0, 2'd2);
    step_b(1'b1, 4'b1100, 1'b0); chk_b("sat3", 4'd8, ER, 1'b0, 2'd3);
    step_b(1'b1, 4'b0000, 1'b0); chk_b("sat4", 4'd0, ER, 1'b0, 2'd3);
    step_b(1'b1, 4'b1100, 1'b0); chk_b("sat5", 4'd8, ER, 1'b0, 2'd3);
    step_b(1'b0, 4'b1100, 1'b0); chk_b("sat_hold", 4'd8, NP, 1'b0, 2'd3);
    step_b(1'b1, 4'b0000, 1'b1); chk_b("sat_clr", 4'd0, ER, 1'b0, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
